fft_stream_iter: RTL and testbench
==================================

// Module: fft_stream_iter
// PURPOSE
//   Parametrised iterative radix-2 DIT FFT/IFFT core with streaming valid/ready I/O.
//   Takes a frame of N complex fixed-point samples in natural order. Computes the FFT
//   in place with one butterfly per clock. Streams the result out in natural order.
//   Next generation of the stage-parallel fft_fp block. Adds runtime-selectable
//   inverse transform, per-frame 1/2-per-stage scaling, saturation with an overflow
//   flag, and backpressure. Sits between the sample front-end and spectral
//   post-processing.
// PARAMETERS
//   N          8    points per frame; power of 2, 4..1024
//   WORD_SIZE  32   bits per complex word; real = [WORD_SIZE-1:WORD_SIZE/2], imag = lower half
//   FRAC       15   fractional bits of each signed half-word (twiddle format Q1.FRAC)
// PORTS
//   clk        in   1          rising-edge clock
//   reset_n    in   1          asynchronous active-low reset
//   in_valid   in   1          input sample valid
//   in_ready   out  1          core can accept a sample
//   in_data    in   WORD_SIZE  input complex sample, natural order
//   inverse    in   1          1 = IFFT (conjugate twiddles); sampled with the first sample of a frame
//   scale_en   in   1          1 = arithmetic >>1 after every stage; sampled with the first sample
//   out_valid  out  1          output sample valid
//   out_ready  in   1          downstream accepts the sample
//   out_data   out  WORD_SIZE  output bin, natural order (bin 0 first)
//   out_last   out  1          high with bin N-1
//   busy       out  1          high in every state except IDLE
//   ovf        out  1          sticky per frame: a saturation occurred; cleared when the next frame's first sample is accepted
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1, out_valid=0, out_last=0, busy=0, ovf=0, out_data=0,
//     counters=0. Reset mid-frame discards the frame; no partial output is ever emitted.
//   Handshake: transfer on a rising edge with valid&ready. out_data/out_last are held
//     stable while out_valid=1 and out_ready=0.
//   FSM states:
//     IDLE    in_ready=1. The first accepted sample latches inverse/scale_en, clears ovf,
//             writes mem[bitrev(0)], then goes to LOAD.
//     LOAD    in_ready=1. Sample k is written to mem[bitrev(k)]. Acceptance of sample N-1
//             goes to COMPUTE.
//     COMPUTE in_ready=0. One butterfly per cycle; stage s = 0..log2N-1, butterfly b = 0..N/2-1.
//             Addresses: a = (b>>s)<<(s+1) | (b & (2^s-1)), c = a + 2^s.
//             Twiddle index = (b & (2^s-1)) << (log2N-1-s).
//             Read and write-back happen in the same cycle (register array), so a later
//             butterfly sees the updated values. Lasts exactly (N/2)*log2N cycles, then UNLOAD.
//     UNLOAD  out_valid=1. Emits mem[0..N-1]; stalls on out_ready=0. Acceptance of bin N-1
//             returns to IDLE, with in_ready=1 on the following cycle.
//   Latency: out_valid rises (N/2)*log2N + 1 edges after the edge accepting input sample
//     N-1. Input and output of different frames do not overlap.
//   Arithmetic:
//     Butterfly: t = mem[c]*W; mem[a] = mem[a] + t; mem[c] = mem[a] - t.
//     W = exp(-j2*pi*k/N), conjugated when inverse=1.
//     Complex products: full precision, + 2^(FRAC-1), arithmetic >>FRAC.
//     Sums are computed 1 bit wider. With scale_en the sum is arithmetic >>1 (truncate).
//     The result then saturates to the signed WORD_SIZE/2 range; any clip sets ovf.
//     Twiddle +1.0 is stored as 2^FRAC-1; -1.0 is exact.
//     IFFT does no 1/N scaling beyond scale_en.
//   Boundaries:
//     in_valid with in_ready=0 is ignored (not queued).
//     inverse/scale_en changes mid-frame are ignored.
//     out_ready held low stalls UNLOAD indefinitely, with no data loss.
// STRUCTURE
//   fft_pkg:
//     - state encoding localparams (IDLE/LOAD/COMPUTE/UNLOAD)
//     - bitrev function
//     - complex pack/unpack
//     - sat_add and round_mul functions
//   Sub-module fft_twiddle_rom #(N,FRAC): combinational cos/sin table of N/2 entries,
//     generated at elaboration; conjugation is done in the core.
//   The core holds the FSM, counters, the N x WORD_SIZE register array and one butterfly datapath.
// TESTING (N=8, WORD_SIZE=32, FRAC=15; output tolerance +-1 LSB)
//   1. Impulse x0=0x4000_0000, others 0, fwd, no scale -> all 8 bins = 0x4000_0000;
//      ovf=0; out_last on bin 7 only.
//   2. DC, all x=0x0800_0000, no scale -> bin0=0x4000_0000, bins1-7=0.
//      Same frame with scale_en=1 -> bin0=0x0800_0000.
//   3. x1=0x2000_0000 only: fwd -> bin2=0x0000_E000. Inverse -> bin2=0x0000_2000,
//      confirming twiddle conjugation.
//   4. All x=0x7FFF_0000, no scale -> bin0=0x7FFF_0000 saturated, ovf=1.
//      Next frame (test 1) clears ovf.
//   5. out_ready toggled randomly, in_valid gapped -> bins identical to test 2;
//      latency from last input to out_valid = 13 edges.
//   6. reset_n low during COMPUTE -> all outputs at reset values at once;
//      next frame (test 1) produces correct output.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding and fixed-point helpers for the iterative FFT core.
// Helpers work on 64-bit signed values; callers pass the half-word width h.
package fft_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
    typedef logic signed [63:0] wide_t;

    function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 32'd1);
        return r;
    endfunction

    function automatic wide_t unpack_re(input logic [63:0] w, input int h);
        wide_t x;
        x = wide_t'(w << (64 - 2 * h));
        return x >>> (64 - h);
    endfunction

    function automatic wide_t unpack_im(input logic [63:0] w, input int h);
        wide_t x;
        x = wide_t'(w << (64 - h));
        return x >>> (64 - h);
    endfunction

    function automatic logic [63:0] pack(input wide_t re, input wide_t im, input int h);
        logic [63:0] m;
        m = (64'd1 << h) - 64'd1;
        return ((re & m) << h) | (im & m);
    endfunction

    function automatic wide_t round_mul(input wide_t p, input int frac);
        return (p + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    // Sum or difference, optional halving (truncating), then clip to h signed bits.
    function automatic wide_t sat_add(input wide_t x, input wide_t y, input logic sub,
                                      input logic half, input int h, output logic clip);
        wide_t s, mx, mn;
        s = sub ? x - y : x + y;
        if (half) s = s >>> 1;
        mx = (64'sd1 <<< (h - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        clip = (s > mx) || (s < mn);
        return (s > mx) ? mx : ((s < mn) ? mn : s);
    endfunction
endpackage

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: combinational table of W^k = exp(-j2*pi*k/N), k < N/2, in Q1.FRAC.
// +1.0 is clamped to 2^FRAC-1; -1.0 is representable exactly.
module fft_twiddle_rom #(
    parameter int N    = 8,
    parameter int FRAC = 15
) (
    input  logic [$clog2(N)-2:0] i_idx,
    output logic signed [FRAC:0] o_re,
    output logic signed [FRAC:0] o_im
);
    localparam int  TW   = FRAC + 1;
    localparam int  MAXV = (1 << FRAC) - 1;
    localparam real PI   = 3.14159265358979323846;

    function automatic int quant(input real v);
        int q;
        q = int'(v * real'(1 << FRAC));
        return (q > MAXV) ? MAXV : q;
    endfunction

    logic signed [FRAC:0] w_re [N/2];
    logic signed [FRAC:0] w_im [N/2];

    for (genvar k = 0; k < N / 2; k++) begin : g_tw
        localparam real ANG = 2.0 * PI * real'(k) / real'(N);
        localparam int  RE  = quant($cos(ANG));
        localparam int  IM  = quant(-$sin(ANG));
        assign w_re[k] = TW'(RE);
        assign w_im[k] = TW'(IM);
    end

    assign o_re = w_re[i_idx];
    assign o_im = w_im[i_idx];
endmodule

// File: rtl/fft_stream_iter.sv
// fft_stream_iter: iterative radix-2 DIT FFT/IFFT, one in-place butterfly per clock,
// bit-reversed load, natural-order streaming unload through a one-entry output register.
module fft_stream_iter
    import fft_pkg::*;
#(
    parameter int N         = 8,
    parameter int WORD_SIZE = 32,
    parameter int FRAC      = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 inverse,
    input  logic                 scale_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 ovf
);
    localparam int LOG = $clog2(N);
    localparam int H   = WORD_SIZE / 2;
    localparam int SW  = $clog2(LOG);
    localparam int LB  = LOG - 1;
    localparam int CW  = LOG + 1;
    localparam logic [CW-1:0] C_LAST   = CW'(N - 1);
    localparam logic [SW-1:0] STG_LAST = SW'(LOG - 1);

    state_t               r_state, w_next;
    logic [WORD_SIZE-1:0] r_mem [N];
    logic [CW-1:0]        r_cnt;
    logic [SW-1:0]        r_stage;
    logic [LB-1:0]        r_bfly;
    logic                 r_inv, r_scale, r_ovf, r_ov, r_ol;
    logic [WORD_SIZE-1:0] r_od;
    logic                 w_in_fire, w_out_fire, w_load_out, w_bf_last, w_clip;
    logic [LOG-1:0]       w_a, w_c, w_wr_addr;
    logic [LB-1:0]        w_tw;
    logic signed [FRAC:0] w_wre, w_wim;
    logic [WORD_SIZE-1:0] w_new_a, w_new_c;

    fft_twiddle_rom #(.N(N), .FRAC(FRAC)) u_rom (.i_idx(w_tw), .o_re(w_wre), .o_im(w_wim));

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign busy       = r_state != S_IDLE;
    assign out_valid  = r_ov;
    assign out_data   = r_od;
    assign out_last   = r_ol;
    assign ovf        = r_ovf;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_ov && out_ready;
    // r_cnt[LOG] marks that every bin has been moved into the output register.
    assign w_load_out = (r_state == S_UNLOAD) && !r_cnt[LOG] && (!r_ov || out_ready);
    assign w_bf_last  = (r_stage == STG_LAST) && (r_bfly == '1);
    assign w_wr_addr  = LOG'(bitrev(32'(r_cnt), LOG));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_in_fire ? S_LOAD : S_IDLE;
            S_LOAD:    w_next = (w_in_fire && r_cnt == C_LAST) ? S_COMPUTE : S_LOAD;
            S_COMPUTE: w_next = w_bf_last ? S_UNLOAD : S_COMPUTE;
            S_UNLOAD:  w_next = (w_out_fire && r_ol) ? S_IDLE : S_UNLOAD;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        int unsigned s, b, a;
        s = 32'(r_stage);
        b = 32'(r_bfly);
        a = ((b >> s) << (s + 1)) | (b & ((32'd1 << s) - 32'd1));
        w_a = LOG'(a);
        w_c = LOG'(a + (32'd1 << s));
        w_tw = LB'((b & ((32'd1 << s) - 32'd1)) << (LOG - 1 - s));
    end

    always_comb begin
        wide_t ar, ai, cr, ci, wr, wi, tr, ti, nar, nai, ncr, nci;
        logic k0, k1, k2, k3;
        ar = unpack_re(64'(r_mem[w_a]), H);
        ai = unpack_im(64'(r_mem[w_a]), H);
        cr = unpack_re(64'(r_mem[w_c]), H);
        ci = unpack_im(64'(r_mem[w_c]), H);
        wr = wide_t'(w_wre);
        wi = r_inv ? -wide_t'(w_wim) : wide_t'(w_wim);
        tr = round_mul(cr * wr - ci * wi, FRAC);
        ti = round_mul(cr * wi + ci * wr, FRAC);
        nar = sat_add(ar, tr, 1'b0, r_scale, H, k0);
        nai = sat_add(ai, ti, 1'b0, r_scale, H, k1);
        ncr = sat_add(ar, tr, 1'b1, r_scale, H, k2);
        nci = sat_add(ai, ti, 1'b1, r_scale, H, k3);
        w_new_a = WORD_SIZE'(pack(nar, nai, H));
        w_new_c = WORD_SIZE'(pack(ncr, nci, H));
        w_clip = k0 | k1 | k2 | k3;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_stage <= '0;
            r_bfly  <= '0;
            r_inv   <= 1'b0;
            r_scale <= 1'b0;
            r_ovf   <= 1'b0;
            r_ov    <= 1'b0;
            r_ol    <= 1'b0;
            r_od    <= '0;
        end else begin
            r_state <= w_next;
            if (w_in_fire) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
            if (w_in_fire && r_state == S_IDLE) begin
                r_inv   <= inverse;
                r_scale <= scale_en;
                r_ovf   <= 1'b0;
            end
            if (r_state == S_COMPUTE) begin
                r_bfly <= r_bfly + 1'b1;
                if (r_bfly == '1) r_stage <= w_bf_last ? '0 : r_stage + 1'b1;
                if (w_clip) r_ovf <= 1'b1;
            end
            if (w_load_out) begin
                r_od  <= r_mem[r_cnt[LOG-1:0]];
                r_ol  <= r_cnt == C_LAST;
                r_ov  <= 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end else if (w_out_fire) begin
                r_ov <= 1'b0;
                r_ol <= 1'b0;
                if (r_ol) r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) r_mem[w_wr_addr] <= in_data;
        if (r_state == S_COMPUTE) begin
            r_mem[w_a] <= w_new_a;
            r_mem[w_c] <= w_new_c;
        end
    end
endmodule

// File: tb/tb_fft_stream_iter.sv
// tb_fft_stream_iter: directed frames with hand-computed bins for the 8-point core.
module tb_fft_stream_iter;
    logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, inverse = 1'b0;
    logic        scale_en = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_last, busy, ovf;
    logic [31:0] out_data;
    logic [31:0] xin [8];
    logic [31:0] got [8];
    logic [7:0]  lastm;
    logic        ovf_first;
    int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, first_cyc = 0, nb = 0, hold_err = 0;

    fft_stream_iter #(.N(8), .WORD_SIZE(32), .FRAC(15)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .inverse(inverse), .scale_en(scale_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int k = 0; k < 8; k++) xin[k] = v;
    endtask

    task automatic push(input logic [31:0] d);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit rnd);
        int t = 0;
        bit stall = 1'b0;
        logic [31:0] held = '0;
        nb = 0; lastm = '0; first_cyc = -1; hold_err = 0;
        while (nb < 8 && t < 400) begin
            @(negedge clk);
            t++;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (stall && (!out_valid || out_data !== held)) hold_err++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                got[nb] = out_data;
                lastm[nb] = out_last;
                nb++;
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Mode bits are flipped after the first sample; the core must keep the first ones.
    task automatic frame(input logic inv, input logic sc, input bit rnd, input bit junk);
        for (int k = 0; k < 8; k++) begin
            inverse  = (k == 0) ? inv : !inv;
            scale_en = (k == 0) ? sc : !sc;
            push(xin[k]);
            if (k == 0) ovf_first = ovf;
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
            repeat (5) @(negedge clk);
            in_valid = 1'b0;
        end
        collect(rnd);
    endtask

    initial begin
        int seen;
        fill('0);
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        fill('0); xin[0] = 32'h4000_0000;
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_count", 32'(nb), 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("t1_bin%0d", k), got[k], 32'h4000_0000);
        chk("t1_last_mask", 32'(lastm), 32'h80);
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_latency", 32'(first_cyc - acc_cyc), 32'd13);
        chk("t1_ready_after", 32'(in_ready), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        fill(32'h0800_0000);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t2_bin%0d", k), got[k], (k == 0) ? 32'h4000_0000 : 32'h0);
        frame(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t2s_bin%0d", k), got[k], (k == 0) ? 32'h0800_0000 : 32'h0);

        fill('0); xin[1] = 32'h2000_0000;
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_fwd_bin0", got[0], 32'h2000_0000);
        chk("t3_fwd_bin2", got[2], 32'h0000_E000);
        frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_inv_bin0", got[0], 32'h2000_0000);
        chk("t3_inv_bin2", got[2], 32'h0000_2000);

        fill(32'h7FFF_0000);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_bin0", got[0], 32'h7FFF_0000);
        chk("t4_ovf", 32'(ovf), 32'd1);
        fill('0); xin[0] = 32'h4000_0000;
        frame(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_ovf_cleared_first", 32'(ovf_first), 32'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("t4n_bin%0d", k), got[k], 32'h4000_0000);
        chk("t4n_ovf", 32'(ovf), 32'd0);

        fill(32'h0800_0000);
        frame(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_count", 32'(nb), 32'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t5_bin%0d", k), got[k], (k == 0) ? 32'h4000_0000 : 32'h0);
        chk("t5_latency", 32'(first_cyc - acc_cyc), 32'd13);
        chk("t5_hold", 32'(hold_err), 32'd0);
        chk("t5_last_mask", 32'(lastm), 32'h80);

        fill(32'h7FFF_0000);
        inverse = 1'b0; scale_en = 1'b0;
        for (int k = 0; k < 8; k++) push(xin[k]);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_out_data", out_data, 32'd0);
        chk("t6_out_last", 32'(out_last), 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        reset_n = 1'b1;
        chk("t6_no_partial", 32'(seen), 32'd0);
        fill('0); xin[0] = 32'h4000_0000;
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_count", 32'(nb), 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("t6_bin%0d", k), got[k], 32'h4000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
